// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC transmit path.
// HDLC_TX_FCS_EN adds the FCS state to the sequencer state encoding.
package hdlc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      OPEN_FLAG,
      DATA,
`ifdef HDLC_TX_FCS_EN
      FCS,
`endif
      CLOSE_FLAG,
      ABORT
   } tx_state_t;

   localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
   localparam logic [7:0]  HDLC_ABORT = 8'hFE;
   localparam logic [15:0] CRC_POLY   = 16'h8408;
   localparam logic [15:0] CRC_INIT   = 16'hFFFF;

endpackage

// File: rtl/hdlc_crc16.sv
// Bit-serial reflected CRC-16 (X.25 polynomial), one data bit per enabled cycle.
// Only instantiated when HDLC_TX_FCS_EN is defined.
module hdlc_crc16
   import hdlc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = CRC_INIT;
      end else if (en_i) begin
         crc_d = (crc_q >> 1) ^ (((crc_q[0] ^ bit_i) == 1'b1) ? CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit frame sequencer: flags, zero-stuffed data, optional FCS, abort and idle.
// Define HDLC_TX_FCS_EN to append the CRC-16/X.25 FCS after the data bytes.
//
// state      | meaning
// IDLE       | line idles at 1, waits for a start request
// OPEN_FLAG  | opening 0x7E, first buffer read issued
// DATA       | data bytes LSB first with zero insertion, next byte prefetched
// FCS        | ones-complemented CRC, low byte first (HDLC_TX_FCS_EN only)
// CLOSE_FLAG | closing 0x7E
// ABORT      | 0xFE abort pattern, then back to IDLE
module hdlc_tx_sequencer
   import hdlc_pkg::*;
#(
   parameter int BUF_DEPTH = 128,
   parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Tx_Enable,
   input  logic              Tx_AbortFrame,
   input  logic [7:0]        Tx_FrameSize,
   output logic              Buf_RdEn,
   output logic [ADDR_W-1:0] Buf_RdAddr,
   input  logic [7:0]        Buf_RdData,
   output logic              Tx,
   output logic              Tx_ValidFrame,
   output logic              Tx_Done,
   output logic              Tx_AbortedTrans,
   output logic              Tx_SizeErr
);

   localparam logic [8:0] MAX_SIZE = 9'(BUF_DEPTH);

   tx_state_t   state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  size_q, size_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  next_q, next_d;
   logic [2:0]  ones_q, ones_d;
   logic        rd_pend_q;
   logic        tx_q, tx_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        rej_q, rej_d;
   logic        size_err_q, size_err_d;

   logic        rd_en;
   logic [7:0]  rd_idx;
   logic        size_ok;
   logic        stuff;
   logic        cur_bit;
   logic [2:0]  ones_nxt;
   logic [7:0]  last_idx;
   tx_state_t   after_data;
   logic        crc_clr, crc_en;

`ifdef HDLC_TX_FCS_EN
   logic [15:0] crc_w;

   hdlc_crc16 u_crc (
      .clk_i (Clk),
      .rst_i (Rst),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .bit_i (shift_q[0]),
      .crc_o (crc_w)
   );
`endif

   assign size_ok = (Tx_FrameSize != 8'd0) && ({1'b0, Tx_FrameSize} <= MAX_SIZE);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_idx_d = byte_idx_q;
      size_d     = size_q;
      shift_d    = shift_q;
      next_d     = rd_pend_q ? Buf_RdData : next_q;
      ones_d     = ones_q;
      tx_d       = 1'b1;
      valid_d    = (state_q != IDLE);
      done_d     = 1'b0;
      aborted_d  = aborted_q;
      rej_d      = 1'b0;
      size_err_d = rej_q;
      rd_en      = 1'b0;
      rd_idx     = 8'd0;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      stuff      = (ones_q == 3'd5);
      cur_bit    = shift_q[0];
      last_idx   = (state_q == DATA) ? (size_q - 8'd1) : 8'd1;
`ifdef HDLC_TX_FCS_EN
      after_data = (state_q == DATA) ? FCS : CLOSE_FLAG;
      if (state_q == FCS) begin
         cur_bit = ~crc_w[{byte_idx_q[0], bit_cnt_q}];
      end
`else
      after_data = CLOSE_FLAG;
`endif
      ones_nxt = cur_bit ? (ones_q + 3'd1) : 3'd0;

      case (state_q)
         IDLE: begin
            // The line has just gone idle after a normally closed frame.
            done_d = valid_q & ~aborted_q;
            if (Tx_Enable) begin
               if (size_ok) begin
                  state_d    = OPEN_FLAG;
                  aborted_d  = 1'b0;
                  size_d     = Tx_FrameSize;
                  byte_idx_d = 8'd0;
                  bit_cnt_d  = 3'd0;
                  ones_d     = 3'd0;
                  crc_clr    = 1'b1;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         OPEN_FLAG: begin
            tx_d      = HDLC_FLAG[bit_cnt_q];
            rd_en     = (bit_cnt_q == 3'd0);
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = DATA;
               shift_d = next_q;
               ones_d  = 3'd0;
            end
            if (Tx_AbortFrame) begin
               state_d   = ABORT;
               bit_cnt_d = 3'd0;
            end
         end
`ifdef HDLC_TX_FCS_EN
         DATA, FCS: begin
`else
         DATA: begin
`endif
            if (stuff) begin
               tx_d   = 1'b0;
               ones_d = 3'd0;
               // byte_idx past the last byte marks a stuffed zero owed after the final bit.
               if (byte_idx_q > last_idx) begin
                  state_d    = after_data;
                  bit_cnt_d  = 3'd0;
                  byte_idx_d = 8'd0;
               end
            end else begin
               tx_d      = cur_bit;
               ones_d    = ones_nxt;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (state_q == DATA) begin
                  shift_d = shift_q >> 1;
                  crc_en  = 1'b1;
                  if (bit_cnt_q == 3'd0 && byte_idx_q < last_idx) begin
                     rd_en  = 1'b1;
                     rd_idx = byte_idx_q + 8'd1;
                  end
               end
               if (bit_cnt_q == 3'd7) begin
                  if (byte_idx_q == last_idx) begin
                     if (ones_nxt == 3'd5) begin
                        byte_idx_d = byte_idx_q + 8'd1;
                     end else begin
                        state_d    = after_data;
                        byte_idx_d = 8'd0;
                     end
                  end else begin
                     byte_idx_d = byte_idx_q + 8'd1;
                     shift_d    = next_q;
                  end
               end
            end
            if (Tx_AbortFrame) begin
               state_d   = ABORT;
               bit_cnt_d = 3'd0;
            end
         end
         CLOSE_FLAG: begin
            tx_d      = HDLC_FLAG[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = IDLE;
            end
         end
         ABORT: begin
            tx_d      = HDLC_ABORT[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q != 3'd0) begin
               aborted_d = 1'b1;
            end
            if (bit_cnt_q == 3'd7) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         byte_idx_q <= 8'd0;
         size_q     <= 8'd0;
         shift_q    <= 8'd0;
         next_q     <= 8'd0;
         ones_q     <= 3'd0;
         rd_pend_q  <= 1'b0;
         tx_q       <= 1'b1;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         rej_q      <= 1'b0;
         size_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_idx_q <= byte_idx_d;
         size_q     <= size_d;
         shift_q    <= shift_d;
         next_q     <= next_d;
         ones_q     <= ones_d;
         rd_pend_q  <= rd_en;
         tx_q       <= tx_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         rej_q      <= rej_d;
         size_err_q <= size_err_d;
      end
   end

   assign Buf_RdEn        = rd_en;
   assign Buf_RdAddr      = ADDR_W'(rd_idx);
   assign Tx              = tx_q;
   assign Tx_ValidFrame   = valid_q;
   assign Tx_Done         = done_q;
   assign Tx_AbortedTrans = aborted_q;
   assign Tx_SizeErr      = size_err_q;

endmodule

// File: doc/hdlc_tx_sequencer.md
# hdlc_tx_sequencer

Frame sequencer for the HDLC transmit path. On a start request it reads `Tx_FrameSize` bytes from the Tx data buffer and drives the serial `Tx` line one bit per `Clk`. The outgoing frame is an opening flag, the data bytes with zero insertion, an optional FCS and a closing flag. It also generates the idle pattern, the abort sequence and the Tx status strobes that the register interface reports.

## Interface
- `BUF_DEPTH`, default 128: Tx buffer depth in bytes; also the maximum legal frame size.
- `ADDR_W`, default `$clog2(BUF_DEPTH)`: width of the buffer address.

- `Clk`  in  1  clock. Single clock domain; every state change happens on the rising edge.
- `Rst`  in  1  reset. Synchronous, active-high.
- `Tx_Enable`  in  1  start-frame pulse.
- `Tx_AbortFrame`  in  1  abort-request pulse.
- `Tx_FrameSize`  in  8  number of data bytes. Sampled when `Tx_Enable` is accepted.
- `Buf_RdEn`  out  1  buffer read strobe.
- `Buf_RdAddr`  out  ADDR_W  buffer read address.
- `Buf_RdData`  in  8  buffer read data. Valid the cycle after `Buf_RdEn`.
- `Tx`  out  1  serial output, LSB first.
- `Tx_ValidFrame`  out  1  high from the first opening-flag bit through the last closing-flag bit or the last abort bit.
- `Tx_Done`  out  1  one-cycle pulse when a frame ends normally.
- `Tx_AbortedTrans`  out  1  sticky abort status.
- `Tx_SizeErr`  out  1  one-cycle pulse when a start request is rejected.

## Operation
- FSM states: IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG, ABORT.
- IDLE:
  - `Tx`=1 (idle pattern); `Tx_ValidFrame`=0.
  - `Tx_Enable` with size 1..BUF_DEPTH: go to OPEN_FLAG, clear `Tx_AbortedTrans`, latch the size, reset the byte counter.
  - `Tx_Enable` with size 0 or size > BUF_DEPTH: pulse `Tx_SizeErr`, stay in IDLE.
- OPEN_FLAG: shift out 0x7E, i.e. bits 0,1,1,1,1,1,1,0. Issue the first buffer read (address 0) during this state so byte 0 is loaded by the end of the flag.
- DATA:
  - Shift each byte LSB first. Prefetch the next byte during the current byte.
  - Addresses run 0..size-1, with no wrap.
  - After the last byte, go to FCS if enabled, otherwise CLOSE_FLAG.
- Zero insertion, applied in DATA and FCS only:
  - A ones counter counts consecutive 1 bits and clears on any 0.
  - When it reaches 5, the next cycle emits a stuffed 0. The shift register and bit counter stall for that cycle, and the counter clears.
  - The counter is zero on entry to DATA. A stuffed 0 may fall after the last data or FCS bit; it is emitted before the closing flag.
  - Flags and the abort pattern are never stuffed.
- CLOSE_FLAG: shift out 0x7E, then return to IDLE and pulse `Tx_Done` in the first IDLE cycle.
- Abort:
  - `Tx_AbortFrame` in OPEN_FLAG, DATA or FCS aborts the frame.
  - The FSM goes to ABORT and shifts 0xFE LSB first (0, then seven 1s), then returns to IDLE.
  - `Tx_AbortedTrans` stays high until the next accepted `Tx_Enable`.
  - In ABORT, no `Tx_Done` pulse and no further buffer reads.
- Ignored requests:
  - `Tx_AbortFrame` in IDLE, CLOSE_FLAG or ABORT.
  - `Tx_Enable` outside IDLE.
  - `Tx_Enable` and `Tx_AbortFrame` together in IDLE: the frame starts and the abort is ignored.

## Timing
- `Tx`, `Tx_ValidFrame`, `Tx_Done`, `Tx_SizeErr` and `Tx_AbortedTrans` are registered.
- Reset values: `Tx`=1, `Buf_RdEn`=0, `Buf_RdAddr`=0; `Tx_ValidFrame`, `Tx_Done`, `Tx_AbortedTrans` and `Tx_SizeErr` all 0. State is IDLE and all counters are 0.
- `Tx_Enable` accepted at edge n: first opening-flag bit on `Tx` at n+1, `Tx_ValidFrame` rises at n+1.
- One bit per cycle. Frame length = 16 + 8·size (+16 with FCS) + number of stuffed zeros.
- `Tx_AbortFrame` sampled at edge n:
  - The current bit completes at n.
  - First abort bit on `Tx` at n+1.
  - `Tx_AbortedTrans` high at n+2.
  - `Tx_ValidFrame` low at n+9.
- `Tx_SizeErr` pulses at n+1 after a rejected start.
- `Rst` mid-frame: `Tx`=1 and all outputs return to reset values on the next edge. No closing flag and no abort pattern is sent.

## Configuration
- Macro `HDLC_TX_FCS_EN`.
- Defined: FCS state present. Appends a CRC-16/X.25 computed over the unstuffed data bits:
  - polynomial 0x8408 (reflected form),
  - initial value 0xFFFF,
  - result ones-complemented,
  - low byte first, LSB first.
- Undefined: no FCS state and no CRC logic; DATA goes directly to CLOSE_FLAG.

## Structure
- Package `hdlc_pkg` holds:
  - the state enum `tx_state_t`;
  - `HDLC_FLAG` = 8'h7E and `HDLC_ABORT` = 8'hFE;
  - `CRC_POLY` = 16'h8408 and `CRC_INIT` = 16'hFFFF.
- Sub-module `hdlc_crc16`, instantiated only under `HDLC_TX_FCS_EN`: a bit-serial CRC with clear, enable and data-bit inputs and a 16-bit output.

## Test plan
- Reset and idle: hold `Rst` 2 cycles, then 20 idle cycles → `Tx`=1 throughout; `Tx_ValidFrame`, `Tx_Done` and `Tx_AbortedTrans` all 0.
- Stuffing (FCS off), 1-byte frame of 0xFF → on `Tx`: 01111110, 111110111, 01111110. `Tx_ValidFrame` high for exactly 25 cycles; `Tx_Done` pulses once.
- FCS (`HDLC_TX_FCS_EN` defined), 9 bytes of ASCII "123456789" → after the data, bytes 0x6E then 0x90 on `Tx`, with any required stuffing; closing flag follows.
- Abort, size=10, `Tx_AbortFrame` during byte 3 at edge n:
  - `Tx` = 0,1,1,1,1,1,1,1 from n+1.
  - `Tx_AbortedTrans`=1 at n+2; `Tx_ValidFrame`=0 at n+9.
  - No `Tx_Done`; `Tx_AbortedTrans` clears on the next `Tx_Enable`.
- Size errors:
  - `Tx_Enable` with size 0 → `Tx_SizeErr` pulse, no frame, `Tx` stays 1.
  - Same for size 129.
- Mid-frame events:
  - `Rst` mid-DATA → `Tx`=1 and state IDLE next cycle.
  - A second `Tx_Enable` mid-frame has no effect on the frame in progress.
